// File: rtl/snn_pkg.sv
// snn_pkg: shared types, defaults and helpers for the SNN output layer.
package snn_pkg;
   typedef enum logic {IDLE = 1'b0, INHIBIT = 1'b1} state_e;
   localparam int P_WIDTH_DEF = 19;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/wta_cmp_stage.sv
// wta_cmp_stage: one registered level of the argmax tree; halves the value/index vectors.
module wta_cmp_stage #(
   parameter int P_PAIRS = 4,
   parameter int P_WIDTH = 19,
   parameter int P_IDXW  = 3
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [2*P_PAIRS*P_WIDTH-1:0]  i_val,
   input  logic [2*P_PAIRS*P_IDXW-1:0]   i_idx,
   input  logic                          i_valid,
   output logic [P_PAIRS*P_WIDTH-1:0]    o_val,
   output logic [P_PAIRS*P_IDXW-1:0]     o_idx,
   output logic                          o_valid
);
   logic [P_PAIRS*P_WIDTH-1:0] val_d, val_q;
   logic [P_PAIRS*P_IDXW-1:0]  idx_d, idx_q;
   logic                       valid_d, valid_q;
   logic [P_PAIRS-1:0]         sel;
   // The upper element of a pair only wins when strictly greater, so ties keep the lower index.
   always_comb begin
      sel = '0;
      val_d = val_q;
      idx_d = idx_q;
      valid_d = i_valid;
      for (int p = 0; p < P_PAIRS; p++) begin
         sel[p] = i_val[(2*p+1)*P_WIDTH +: P_WIDTH] > i_val[2*p*P_WIDTH +: P_WIDTH];
         if (i_valid) begin
            val_d[p*P_WIDTH +: P_WIDTH] = sel[p] ? i_val[(2*p+1)*P_WIDTH +: P_WIDTH] : i_val[2*p*P_WIDTH +: P_WIDTH];
            idx_d[p*P_IDXW +: P_IDXW]   = sel[p] ? i_idx[(2*p+1)*P_IDXW +: P_IDXW] : i_idx[2*p*P_IDXW +: P_IDXW];
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         val_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         val_q   <= val_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end
   assign o_val   = val_q;
   assign o_idx   = idx_q;
   assign o_valid = valid_q;
endmodule

// File: rtl/snn_wta_argmax.sv
// snn_wta_argmax: pipelined winner-take-all over P_NUM potentials with threshold gate
// and a refractory window counted in valid samples.
module snn_wta_argmax import snn_pkg::*; #(
   parameter int P_WIDTH = P_WIDTH_DEF,
   parameter int P_NUM   = 8,
   parameter int P_IDXW  = clog2(P_NUM),
   parameter int P_INHW  = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [P_NUM*P_WIDTH-1:0] i_data,
   input  logic [P_WIDTH-1:0]       i_thresh,
   input  logic [P_INHW-1:0]        i_inh_len,
   input  logic                     i_clear,
   output logic                     o_valid,
   output logic [P_WIDTH-1:0]       o_result,
   output logic [P_IDXW-1:0]        o_index_bin,
   output logic [P_NUM-1:0]         o_index,
   output logic                     o_fire,
   output logic                     o_inhibit
);
   localparam int P_L = clog2(P_NUM);
   logic [P_NUM*P_IDXW-1:0] idx0;
   logic [P_WIDTH-1:0]      tmax;
   logic [P_IDXW-1:0]       tidx;
   logic                    tvld, win, fire;
   state_e                  state_d, state_q;
   logic [P_INHW-1:0]       cnt_d, cnt_q;
   logic [P_NUM-1:0]        index_d, index_q;
   always_comb begin
      idx0 = '0;
      for (int k = 0; k < P_NUM; k++) idx0[k*P_IDXW +: P_IDXW] = P_IDXW'(k);
   end
   for (genvar l = 0; l < P_L; l++) begin : g_lvl
      localparam int NP = P_NUM >> (l + 1);
      logic [NP*P_WIDTH-1:0] val;
      logic [NP*P_IDXW-1:0]  idx;
      logic                  vld;
      if (l == 0) begin : g_first
         wta_cmp_stage #(.P_PAIRS(NP), .P_WIDTH(P_WIDTH), .P_IDXW(P_IDXW)) u_stage (
            .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(i_data), .i_idx(idx0), .i_valid(i_valid),
            .o_val(val), .o_idx(idx), .o_valid(vld));
      end else begin : g_next
         wta_cmp_stage #(.P_PAIRS(NP), .P_WIDTH(P_WIDTH), .P_IDXW(P_IDXW)) u_stage (
            .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(g_lvl[l-1].val), .i_idx(g_lvl[l-1].idx),
            .i_valid(g_lvl[l-1].vld), .o_val(val), .o_idx(idx), .o_valid(vld));
      end
   end
   assign tmax = g_lvl[P_L-1].val;
   assign tidx = g_lvl[P_L-1].idx;
   assign tvld = g_lvl[P_L-1].vld;
   assign win  = tvld && (tmax != '0) && (tmax >= i_thresh);
   // Fire and the latched one-hot are combinational so they line up with the tree output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      index_d = index_q;
      fire    = 1'b0;
      if (i_clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         index_d = '0;
      end else if (state_q == IDLE) begin
         if (win) begin
            fire    = 1'b1;
            index_d = P_NUM'(1) << tidx;
            state_d = (i_inh_len != '0) ? INHIBIT : IDLE;
            cnt_d   = i_inh_len;
         end
      end else if (tvld) begin
         cnt_d   = cnt_q - P_INHW'(1);
         state_d = (cnt_q == P_INHW'(1)) ? IDLE : INHIBIT;
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         index_q <= index_d;
      end
   end
   assign o_valid     = tvld;
   assign o_result    = tmax;
   assign o_index_bin = tidx;
   assign o_index     = index_d;
   assign o_fire      = fire;
   assign o_inhibit   = (state_q == INHIBIT);
endmodule
